// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the UART program loader.
package prog_loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = 32;

  // Terminator word: marks end of program, never written to memory.
  localparam logic [WORD_W-1:0] LDR_END_WORD = 32'h0000_0FFF;

  typedef enum logic [1:0] {
    LOAD,
    WRITE,
    DONE
  } ldr_state_e;

endpackage

// File: rtl/byte_word_packer.sv
// Little-endian byte-to-word packer: byte k lands in bits [8k+7:8k]. The completed
// word and its strobe are combinational so the caller sees them on the cycle that
// carries byte 3.
module byte_word_packer
  import prog_loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rx_valid_i,
  input  logic [BYTE_W-1:0] rx_byte_i,
  output logic              word_valid_c_o,
  output logic [WORD_W-1:0] word_c_o
);

  localparam int unsigned CNT_W  = $clog2(BYTES_PER_WORD);
  localparam int unsigned PART_W = WORD_W - BYTE_W;

  logic [CNT_W-1:0]  cnt_q,  cnt_d;
  logic [PART_W-1:0] part_q, part_d;

  // Advance the byte counter and capture the lower three bytes.
  always_comb begin
    cnt_d  = cnt_q;
    part_d = part_q;
    if (rx_valid_i) begin
      cnt_d = cnt_q + CNT_W'(1);
      case (cnt_q)
        CNT_W'(0): part_d[7:0]   = rx_byte_i;
        CNT_W'(1): part_d[15:8]  = rx_byte_i;
        CNT_W'(2): part_d[23:16] = rx_byte_i;
        default:   part_d        = part_q;
      endcase
    end
  end

  // Counter and partial-word registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      part_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      part_q <= part_d;
    end
  end

  assign word_valid_c_o = rx_valid_i && (cnt_q == CNT_W'(BYTES_PER_WORD - 1));
  assign word_c_o       = {rx_byte_i, part_q};

endmodule

// File: rtl/uart_prog_loader.sv
// UART program loader: packs received bytes into words, writes them sequentially
// to instruction memory and holds the core in reset until the terminator word.
// Optional feature macro: LOADER_CHECKSUM_EN (running XOR of written words).
module uart_prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 13,
  parameter int unsigned       BASE_ADDR = 0,
  parameter logic [WORD_W-1:0] END_WORD  = LDR_END_WORD
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              rx_valid_i,
  input  logic [BYTE_W-1:0] rx_byte_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [WORD_W-1:0] imem_wdata_o,
  input  logic              imem_ready_i,
  output logic              core_rst_o,
  output logic              load_done_o,
  output logic              err_o,
  output logic [ADDR_W:0]   word_count_o,
  output logic [WORD_W-1:0] checksum_o
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  ldr_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              core_rst_q, core_rst_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              end_pend_q, end_pend_d;
  logic              ovf_q, ovf_d;

  logic              accept_c;
  logic              word_valid_c;
  logic [WORD_W-1:0] word_c;
  logic              is_end_c;
  logic              wr_done_c;

  // Bytes are ignored once loading is finished.
  assign accept_c  = rx_valid_i && (state_q != DONE);
  assign is_end_c  = word_valid_c && (word_c == END_WORD);
  assign wr_done_c = (state_q == WRITE) && imem_ready_i;

  byte_word_packer u_packer (
    .clk_i          (wb_clk_i),
    .rst_i          (wb_rst_i),
    .rx_valid_i     (accept_c),
    .rx_byte_i      (rx_byte_i),
    .word_valid_c_o (word_valid_c),
    .word_c_o       (word_c)
  );

  // Next-state and output logic for the LOAD/WRITE/DONE controller.
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    done_d     = done_q;
    core_rst_d = core_rst_q;
    err_d      = err_q;
    count_d    = count_q;
    end_pend_d = end_pend_q;
    ovf_d      = ovf_q;
    case (state_q)
      LOAD: begin
        if (is_end_c) begin
          state_d    = DONE;
          done_d     = 1'b1;
          core_rst_d = 1'b0;
        end else if (word_valid_c) begin
          if (ovf_q) begin
            err_d = 1'b1;
          end else begin
            we_d    = 1'b1;
            wdata_d = word_c;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        if (imem_ready_i) begin
          we_d    = 1'b0;
          count_d = count_q + CNT_W'(1);
          // Last address: flag overflow instead of wrapping.
          if (&addr_q) ovf_d = 1'b1;
          else         addr_d = addr_q + ADDR_W'(1);
          if (end_pend_q || is_end_c) begin
            state_d    = DONE;
            done_d     = 1'b1;
            core_rst_d = 1'b0;
            end_pend_d = 1'b0;
          end else begin
            state_d = LOAD;
          end
          // Write is still pending on this cycle, so a fresh data word is lost.
          if (word_valid_c && !is_end_c) err_d = 1'b1;
        end else if (is_end_c) begin
          end_pend_d = 1'b1;
        end else if (word_valid_c) begin
          err_d = 1'b1;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  // Controller registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= LOAD;
      we_q       <= 1'b0;
      addr_q     <= ADDR_W'(BASE_ADDR);
      wdata_q    <= '0;
      done_q     <= 1'b0;
      core_rst_q <= 1'b1;
      err_q      <= 1'b0;
      count_q    <= '0;
      end_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
      core_rst_q <= core_rst_d;
      err_q      <= err_d;
      count_q    <= count_d;
      end_pend_q <= end_pend_d;
      ovf_q      <= ovf_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] csum_q, csum_d;

  // Fold each word into the checksum as its write completes.
  always_comb begin
    csum_d = csum_q;
    if (wr_done_c) csum_d = csum_q ^ wdata_q;
  end

  // Checksum register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) csum_q <= '0;
    else          csum_q <= csum_d;
  end

  assign checksum_o = csum_q;
`else
  assign checksum_o = '0;
`endif

  assign imem_we_o    = we_q;
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;
  assign core_rst_o   = core_rst_q;
  assign load_done_o  = done_q;
  assign err_o        = err_q;
  assign word_count_o = count_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench for uart_prog_loader: a full-size instance plus an ADDR_W=2
// instance for the overflow case. Expected writes are queued when stimulus is sent
// and popped by per-instance monitors when the memory accepts a write.
module tb_uart_prog_loader;

  localparam int unsigned BIG_W   = 13;
  localparam int unsigned SMALL_W = 2;
  localparam logic [31:0] ENDW    = 32'h0000_0FFF;

  typedef struct packed {
    logic [12:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Full-size instance signals
  logic              rst = 1'b1;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_byte = 8'h00;
  logic              ready = 1'b1;
  logic              we;
  logic [BIG_W-1:0]  addr;
  logic [31:0]       wdata;
  logic              core_rst, load_done, err;
  logic [BIG_W:0]    wcount;
  logic [31:0]       csum;

  // Small instance signals
  logic              s_rst = 1'b1;
  logic              s_rx_valid = 1'b0;
  logic [7:0]        s_rx_byte = 8'h00;
  logic              s_ready = 1'b1;
  logic              s_we;
  logic [SMALL_W-1:0] s_addr;
  logic [31:0]       s_wdata;
  logic              s_core_rst, s_load_done, s_err;
  logic [SMALL_W:0]  s_wcount;
  logic [31:0]       s_csum;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  int s_wr_cnt = 0;
  wr_t exp_q[$];
  wr_t s_exp_q[$];

  uart_prog_loader dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .rx_valid_i   (rx_valid),
    .rx_byte_i    (rx_byte),
    .imem_we_o    (we),
    .imem_addr_o  (addr),
    .imem_wdata_o (wdata),
    .imem_ready_i (ready),
    .core_rst_o   (core_rst),
    .load_done_o  (load_done),
    .err_o        (err),
    .word_count_o (wcount),
    .checksum_o   (csum)
  );

  uart_prog_loader #(.ADDR_W(SMALL_W)) dut_s (
    .wb_clk_i     (clk),
    .wb_rst_i     (s_rst),
    .rx_valid_i   (s_rx_valid),
    .rx_byte_i    (s_rx_byte),
    .imem_we_o    (s_we),
    .imem_addr_o  (s_addr),
    .imem_wdata_o (s_wdata),
    .imem_ready_i (s_ready),
    .core_rst_o   (s_core_rst),
    .load_done_o  (s_load_done),
    .err_o        (s_err),
    .word_count_o (s_wcount),
    .checksum_o   (s_csum)
  );

  // Write monitor, full-size instance
  always @(negedge clk) begin
    if (!rst && we && ready) begin
      wr_t e;
      checks++;
      wr_cnt++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL big_write: unexpected write addr=%0h data=%08h", addr, wdata);
      end else begin
        e = exp_q.pop_front();
        if (addr !== e.addr || wdata !== e.data) begin
          errors++;
          $display("FAIL big_write: got addr=%0h data=%08h, want addr=%0h data=%08h",
                   addr, wdata, e.addr, e.data);
        end
      end
    end
  end

  // Write monitor, small instance
  always @(negedge clk) begin
    if (!s_rst && s_we && s_ready) begin
      wr_t e;
      checks++;
      s_wr_cnt++;
      if (s_exp_q.size() == 0) begin
        errors++;
        $display("FAIL small_write: unexpected write addr=%0h data=%08h", s_addr, s_wdata);
      end else begin
        e = s_exp_q.pop_front();
        if (13'(s_addr) !== e.addr || s_wdata !== e.data) begin
          errors++;
          $display("FAIL small_write: got addr=%0h data=%08h, want addr=%0h data=%08h",
                   s_addr, s_wdata, e.addr, e.data);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  task automatic send_byte(input logic [7:0] b, input bit sel);
    @(posedge clk); #1;
    if (sel) begin s_rx_valid = 1'b1; s_rx_byte = b; end
    else     begin rx_valid   = 1'b1; rx_byte   = b; end
    @(posedge clk); #1;
    s_rx_valid = 1'b0;
    rx_valid   = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit sel);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], sel);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({we, addr, wdata} !== {1'b0, 13'd0, 32'd0}) begin
      errors++;
      $display("FAIL reset_bus: we=%b addr=%0h data=%08h, want 0/0/0", we, addr, wdata);
    end
    checks++;
    if ({core_rst, load_done, err} !== 3'b100) begin
      errors++;
      $display("FAIL reset_flags: core_rst/done/err=%b, want 100", {core_rst, load_done, err});
    end
    checks++;
    if (wcount !== '0 || csum !== '0) begin
      errors++;
      $display("FAIL reset_counts: count=%0d csum=%08h, want 0/0", wcount, csum);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_word();
    int w0;
    pulse_reset();
    ready = 1'b1;
    w0 = wr_cnt;
    exp_q.push_back('{addr: 13'd0, data: 32'h0000_0013});
    send_word(32'h0000_0013, 1'b0);
    send_byte(8'hFF, 1'b0); send_byte(8'h0F, 1'b0); send_byte(8'h00, 1'b0);
    checks++;
    if (load_done !== 1'b0 || core_rst !== 1'b1) begin
      errors++;
      $display("FAIL single_early_done: done=%b core_rst=%b, want 0/1", load_done, core_rst);
    end
    send_byte(8'h00, 1'b0);
    checks++;
    if (load_done !== 1'b1 || core_rst !== 1'b0) begin
      errors++;
      $display("FAIL single_done: done=%b core_rst=%b, want 1/0", load_done, core_rst);
    end
    checks++;
    if (wcount !== 14'd1 || (wr_cnt - w0) != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_count: count=%0d writes=%0d pending=%0d, want 1/1/0",
               wcount, wr_cnt - w0, exp_q.size());
    end
  endtask

  task automatic test_wait_states();
    int w0;
    pulse_reset();
    ready = 1'b0;
    w0 = wr_cnt;
    exp_q.push_back('{addr: 13'd0, data: 32'h1234_5678});
    send_word(32'h1234_5678, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (we !== 1'b1 || addr !== 13'd0 || wdata !== 32'h1234_5678) begin
        errors++;
        $display("FAIL wait_hold[%0d]: we=%b addr=%0h data=%08h, want 1/0/12345678",
                 i, we, addr, wdata);
      end
      if (i == 4) ready = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (we !== 1'b0 || (wr_cnt - w0) != 1 || addr !== 13'd1) begin
      errors++;
      $display("FAIL wait_release: we=%b writes=%0d addr=%0h, want 0/1/1", we, wr_cnt - w0, addr);
    end
    exp_q.push_back('{addr: 13'd1, data: 32'hCAFE_F00D});
    send_word(32'hCAFE_F00D, 1'b0);
    idle(2);
    checks++;
    if (wcount !== 14'd2 || (wr_cnt - w0) != 2 || err !== 1'b0) begin
      errors++;
      $display("FAIL wait_second: count=%0d writes=%0d err=%b, want 2/2/0", wcount, wr_cnt - w0, err);
    end
  endtask

  task automatic test_reset_mid_word();
    pulse_reset();
    ready = 1'b1;
    send_byte(8'h55, 1'b0); send_byte(8'h66, 1'b0);
    pulse_reset();
    exp_q.push_back('{addr: 13'd0, data: 32'hDDCC_BBAA});
    send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b0); send_byte(8'hDD, 1'b0);
    idle(2);
    checks++;
    if (err !== 1'b0 || wcount !== 14'd1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL midword_reset: err=%b count=%0d pending=%0d, want 0/1/0",
               err, wcount, exp_q.size());
    end
  endtask

  task automatic test_done_freeze();
    logic [BIG_W:0]   c0;
    logic [BIG_W-1:0] a0;
    logic [31:0]      d0;
    bit               seen_we;
    send_word(ENDW, 1'b0);
    c0 = wcount; a0 = addr; d0 = wdata; seen_we = 1'b0;
    for (int i = 0; i < 12; i++) begin
      send_byte(8'(8'h10 + i), 1'b0);
      if (we !== 1'b0) seen_we = 1'b1;
    end
    idle(2);
    checks++;
    if (seen_we || load_done !== 1'b1 || core_rst !== 1'b0) begin
      errors++;
      $display("FAIL done_flags: seen_we=%b done=%b core_rst=%b, want 0/1/0",
               seen_we, load_done, core_rst);
    end
    checks++;
    if (wcount !== c0 || addr !== a0 || wdata !== d0) begin
      errors++;
      $display("FAIL done_frozen: count=%0d addr=%0h data=%08h, want %0d/%0h/%08h",
               wcount, addr, wdata, c0, a0, d0);
    end
  endtask

  task automatic test_back_to_back();
    pulse_reset();
    ready = 1'b0;
    exp_q.push_back('{addr: 13'd0, data: 32'hA5A5_0001});
    send_word(32'hA5A5_0001, 1'b0);
    send_word(32'hA5A5_0002, 1'b0);
    checks++;
    if (err !== 1'b1 || we !== 1'b1 || wdata !== 32'hA5A5_0001) begin
      errors++;
      $display("FAIL b2b_drop: err=%b we=%b data=%08h, want 1/1/a5a50001", err, we, wdata);
    end
    send_word(ENDW, 1'b0);
    checks++;
    if (load_done !== 1'b0 || we !== 1'b1) begin
      errors++;
      $display("FAIL b2b_end_pending: done=%b we=%b, want 0/1", load_done, we);
    end
    ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (we !== 1'b0 || load_done !== 1'b1 || core_rst !== 1'b0 || wcount !== 14'd1 || addr !== 13'd1) begin
      errors++;
      $display("FAIL b2b_end_done: we=%b done=%b core_rst=%b count=%0d addr=%0h, want 0/1/0/1/1",
               we, load_done, core_rst, wcount, addr);
    end
  endtask

  task automatic test_overflow();
    @(posedge clk); #1; s_rst = 1'b1;
    @(posedge clk); #1; s_rst = 1'b0;
    s_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_exp_q.push_back('{addr: 13'(i), data: 32'h1000_0000 + 32'(i)});
      send_word(32'h1000_0000 + 32'(i), 1'b1);
    end
    idle(2);
    checks++;
    if (s_err !== 1'b0 || s_wcount !== 3'd4 || s_addr !== 2'd3) begin
      errors++;
      $display("FAIL ovf_fill: err=%b count=%0d addr=%0h, want 0/4/3", s_err, s_wcount, s_addr);
    end
    send_word(32'h1000_0004, 1'b1);
    send_word(ENDW, 1'b1);
    idle(2);
    checks++;
    if (s_err !== 1'b1 || s_load_done !== 1'b1 || s_core_rst !== 1'b0) begin
      errors++;
      $display("FAIL ovf_flags: err=%b done=%b core_rst=%b, want 1/1/0", s_err, s_load_done, s_core_rst);
    end
    checks++;
    if (s_wcount !== 3'd4 || s_addr !== 2'd3 || s_wr_cnt != 4 || s_exp_q.size() != 0) begin
      errors++;
      $display("FAIL ovf_counts: count=%0d addr=%0h writes=%0d pending=%0d, want 4/3/4/0",
               s_wcount, s_addr, s_wr_cnt, s_exp_q.size());
    end
  endtask

  task automatic test_checksum();
    logic [31:0] exp_csum;
`ifdef LOADER_CHECKSUM_EN
    exp_csum = 32'h0000_0007;
`else
    exp_csum = 32'h0000_0000;
`endif
    pulse_reset();
    ready = 1'b1;
    exp_q.push_back('{addr: 13'd0, data: 32'd1});
    exp_q.push_back('{addr: 13'd1, data: 32'd2});
    exp_q.push_back('{addr: 13'd2, data: 32'd4});
    send_word(32'd1, 1'b0);
    send_word(32'd2, 1'b0);
    send_word(32'd4, 1'b0);
    send_word(ENDW, 1'b0);
    idle(2);
    checks++;
    if (csum !== exp_csum || wcount !== 14'd3 || load_done !== 1'b1) begin
      errors++;
      $display("FAIL checksum: csum=%08h count=%0d done=%b, want %08h/3/1",
               csum, wcount, load_done, exp_csum);
    end
  endtask

  initial begin
    idle(2);
    test_reset();
    test_single_word();
    test_wait_states();
    test_reset_mid_word();
    test_done_freeze();
    test_back_to_back();
    test_overflow();
    test_checksum();
    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
